// File: rtl/arith_pkg.sv
// Shared widths and types for the arithmetic unit.
// Bit 1 of the architectural registers (the MSB) maps to index MAG_W-1,
// bit 30 (the LSB) maps to index 0; B[0] sits at index B_W-1.
package arith_pkg;

    localparam int MAG_W = 30;  // A, C and the magnitude part of B
    localparam int B_W   = 31;  // B including its overflow bit B[0]
    localparam int IO_W  = 4;   // serial output nibble C[1:4]

    typedef logic [MAG_W-1:0] mag_t;
    typedef logic [B_W-1:0]   breg_t;

    // Logical right shift of a magnitude by one, feeding fill_bit into the MSB.
    function automatic mag_t shr1(input mag_t v, input logic fill_bit);
        return {fill_bit, v[MAG_W-1:1]};
    endfunction

endpackage

// File: rtl/arith_adder.sv
// 30-bit combinational adder shared by the carry status output and do_sum.
module arith_adder
    import arith_pkg::*;
(
    input  logic [MAG_W-1:0] a_in,
    input  logic [MAG_W-1:0] b_in,
    output logic [MAG_W-1:0] sum_out,
    output logic             carry_out
);

    // Widen by one bit so the carry out of bit 1 falls out of the add.
    always_comb begin
        {carry_out, sum_out} = {1'b0, a_in} + {1'b0, b_in};
    end

endmodule

// File: rtl/arith_unit.sv
// Arithmetic unit datapath: accumulator A, B with overflow bit, and C.
// Each register picks one update per cycle from the command pulses in a
// fixed priority order; sum together with right shift forms a multiply step.
module arith_unit
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,

    input  logic             do_clear_a_from_ac,
    input  logic             do_clear_b_from_ac,
    input  logic             do_clear_c_from_ac,
    input  logic             do_not_a_from_ac,
    input  logic             do_not_b_from_ac,
    input  logic             do_sum_from_ac,
    input  logic             do_and_from_ac,
    input  logic             do_set_c_30_from_ac,
    input  logic             do_left_shift_b_from_ac,
    input  logic             do_left_shift_c_from_ac,
    input  logic             do_left_shift_c29_from_ac,
    input  logic             do_right_shift_bc_from_ac,
    input  logic             do_move_c_to_a_from_ac,
    input  logic             do_move_c_to_b_from_ac,
    input  logic             do_move_b_to_c_from_ac,
    input  logic             do_mem_to_c_from_ac,

    input  logic [MAG_W-1:0] read_data_from_mem,
    input  logic             shift_in_bit_from_io,

    input  logic             do_arr_c_from_pnl,
    input  logic [MAG_W-1:0] arr_reg_c_from_pnl,

    output logic             carry_out_to_ac,
    output logic             reg_c1_to_ac,
    output logic             reg_c30_to_ac,
    output logic             reg_b0_to_ac,

    output logic [MAG_W-1:0] reg_a_to_pnl,
    output logic [B_W-1:0]   reg_b_to_pnl,
    output logic [MAG_W-1:0] reg_c_to_pnl,
    output logic [MAG_W-1:0] write_data_to_mem,
    output logic [IO_W-1:0]  output_bits_to_io
);

    mag_t  a_q, a_d;
    breg_t b_q, b_d;
    mag_t  c_q, c_d;

    mag_t  add_sum;
    logic  add_carry;
    logic  mul_step;
    logic  c_shift_fill;

    arith_adder u_adder (
        .a_in      (a_q),
        .b_in      (b_q[MAG_W-1:0]),
        .sum_out   (add_sum),
        .carry_out (add_carry)
    );

    // A multiply step shifts the fresh sum, so its LSB (not old B[30]) moves into C[1].
    assign mul_step     = do_sum_from_ac && do_right_shift_bc_from_ac;
    assign c_shift_fill = mul_step ? add_sum[0] : b_q[0];

    // Next value of A: clear, then move from C, then complement.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        a_d = a_q;
        if (do_clear_a_from_ac) begin
            a_d = '0;
        end else if (do_move_c_to_a_from_ac) begin
            a_d = c_q;
        end else if (do_not_a_from_ac) begin
            a_d = ~a_q;
        end
    end

    // Next value of B: clear, move from C, sum (optionally shifted), left shift, right shift, complement.
    always_comb begin
        b_d = b_q;
        if (do_clear_b_from_ac) begin
            b_d = '0;
        end else if (do_move_c_to_b_from_ac) begin
            b_d = {1'b0, c_q};
        end else if (do_sum_from_ac) begin
            if (do_right_shift_bc_from_ac) begin
                b_d = {1'b0, add_carry, add_sum[MAG_W-1:1]};
            end else begin
                b_d = {add_carry, add_sum};
            end
        end else if (do_left_shift_b_from_ac) begin
            b_d = {b_q[MAG_W-1:0], c_q[MAG_W-1]};
        end else if (do_right_shift_bc_from_ac) begin
            b_d = {1'b0, b_q[B_W-1:1]};
        end else if (do_not_b_from_ac) begin
            b_d = {b_q[B_W-1], ~b_q[MAG_W-1:0]};
        end
    end

    // Next value of C: clear, move from B, memory, panel, AND, then shifts with optional set of C[30].
    always_comb begin
        c_d = c_q;
        if (do_clear_c_from_ac) begin
            c_d = '0;
        end else if (do_move_b_to_c_from_ac) begin
            c_d = b_q[MAG_W-1:0];
        end else if (do_mem_to_c_from_ac) begin
            c_d = read_data_from_mem;
        end else if (do_arr_c_from_pnl) begin
            c_d = arr_reg_c_from_pnl;
        end else if (do_and_from_ac) begin
            c_d = a_q & c_q;
        end else begin
            if (do_right_shift_bc_from_ac) begin
                c_d = shr1(c_q, c_shift_fill);
            end else if (do_left_shift_c_from_ac) begin
                if (do_left_shift_c29_from_ac) begin
                    c_d = {c_q[MAG_W-2:1], shift_in_bit_from_io, 1'b0};
                end else begin
                    c_d = {c_q[MAG_W-2:0], shift_in_bit_from_io};
                end
            end
            // Setting C[30] lands on top of whatever shift happened this cycle.
            if (do_set_c_30_from_ac) begin
                c_d[0] = 1'b1;
            end
        end
    end

    // Register state; asynchronous clear on resetn low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values, which makes B<->C swaps legal.
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign carry_out_to_ac   = add_carry;
    assign reg_c1_to_ac      = c_q[MAG_W-1];
    assign reg_c30_to_ac     = c_q[0];
    assign reg_b0_to_ac      = b_q[B_W-1];
    assign reg_a_to_pnl      = a_q;
    assign reg_b_to_pnl      = b_q;
    assign reg_c_to_pnl      = c_q;
    assign write_data_to_mem = c_q;
    assign output_bits_to_io = c_q[MAG_W-1 -: IO_W];

endmodule

// File: tb/tb_arith_unit.sv
// Self-checking bench for arith_unit: a table of single-command vectors with
// hand-computed results, plus multiply and reset sequences.
module tb_arith_unit;
    import arith_pkg::*;

    typedef logic [16:0] cmd_t;

    localparam cmd_t K_CLR_A = 17'h00001;
    localparam cmd_t K_CLR_B = 17'h00002;
    localparam cmd_t K_CLR_C = 17'h00004;
    localparam cmd_t K_NOT_A = 17'h00008;
    localparam cmd_t K_NOT_B = 17'h00010;
    localparam cmd_t K_SUM   = 17'h00020;
    localparam cmd_t K_AND   = 17'h00040;
    localparam cmd_t K_SET   = 17'h00080;
    localparam cmd_t K_LSB   = 17'h00100;
    localparam cmd_t K_LSC   = 17'h00200;
    localparam cmd_t K_LSC29 = 17'h00400;
    localparam cmd_t K_RSH   = 17'h00800;
    localparam cmd_t K_C2A   = 17'h01000;
    localparam cmd_t K_C2B   = 17'h02000;
    localparam cmd_t K_B2C   = 17'h04000;
    localparam cmd_t K_MEM   = 17'h08000;
    localparam cmd_t K_ARR   = 17'h10000;

    typedef struct {
        string          name;
        logic [29:0]    a, b, c;      // preload values (B[0] preloads as 0)
        cmd_t           cmd;
        logic           sin;
        logic [29:0]    mem, pnl;
        logic [29:0]    ea;
        logic [30:0]    eb;
        logic [29:0]    ec;
    } vec_t;

    typedef struct {
        string          name;
        logic [29:0]    a;
        logic [30:0]    b;
        logic [29:0]    c;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic do_clear_a, do_clear_b, do_clear_c, do_not_a, do_not_b, do_sum, do_and, do_set_c_30;
    logic do_lsb, do_lsc, do_lsc29, do_rsh, do_c2a, do_c2b, do_b2c, do_mem, do_arr;
    logic [29:0] mem_data, pnl_data;
    logic        sin_bit;
    logic        carry_out, c1, c30, b0;
    logic [29:0] reg_a, reg_c, wdata;
    logic [30:0] reg_b;
    logic [3:0]  io_bits;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    arith_unit dut (
        .clk                       (clk),
        .resetn                    (resetn),
        .do_clear_a_from_ac        (do_clear_a),
        .do_clear_b_from_ac        (do_clear_b),
        .do_clear_c_from_ac        (do_clear_c),
        .do_not_a_from_ac          (do_not_a),
        .do_not_b_from_ac          (do_not_b),
        .do_sum_from_ac            (do_sum),
        .do_and_from_ac            (do_and),
        .do_set_c_30_from_ac       (do_set_c_30),
        .do_left_shift_b_from_ac   (do_lsb),
        .do_left_shift_c_from_ac   (do_lsc),
        .do_left_shift_c29_from_ac (do_lsc29),
        .do_right_shift_bc_from_ac (do_rsh),
        .do_move_c_to_a_from_ac    (do_c2a),
        .do_move_c_to_b_from_ac    (do_c2b),
        .do_move_b_to_c_from_ac    (do_b2c),
        .do_mem_to_c_from_ac       (do_mem),
        .read_data_from_mem        (mem_data),
        .shift_in_bit_from_io      (sin_bit),
        .do_arr_c_from_pnl         (do_arr),
        .arr_reg_c_from_pnl        (pnl_data),
        .carry_out_to_ac           (carry_out),
        .reg_c1_to_ac              (c1),
        .reg_c30_to_ac             (c30),
        .reg_b0_to_ac              (b0),
        .reg_a_to_pnl              (reg_a),
        .reg_b_to_pnl              (reg_b),
        .reg_c_to_pnl              (reg_c),
        .write_data_to_mem         (wdata),
        .output_bits_to_io         (io_bits)
    );

    task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_cmd(input cmd_t cmd, input logic sin, input logic [29:0] mem, input logic [29:0] pnl);
        do_clear_a  = cmd[0];
        do_clear_b  = cmd[1];
        do_clear_c  = cmd[2];
        do_not_a    = cmd[3];
        do_not_b    = cmd[4];
        do_sum      = cmd[5];
        do_and      = cmd[6];
        do_set_c_30 = cmd[7];
        do_lsb      = cmd[8];
        do_lsc      = cmd[9];
        do_lsc29    = cmd[10];
        do_rsh      = cmd[11];
        do_c2a      = cmd[12];
        do_c2b      = cmd[13];
        do_b2c      = cmd[14];
        do_mem      = cmd[15];
        do_arr      = cmd[16];
        sin_bit     = sin;
        mem_data    = mem;
        pnl_data    = pnl;
    endtask

    // One command cycle: drive on the falling edge, let the rising edge take it, release after.
    task automatic drive(input cmd_t cmd, input logic sin, input logic [29:0] mem, input logic [29:0] pnl);
        @(negedge clk);
        set_cmd(cmd, sin, mem, pnl);
        @(posedge clk);
        #1;
        set_cmd('0, 1'b0, '0, '0);
    endtask

    // Load B, A, C through the memory path in three cycles.
    task automatic preload(input logic [29:0] a, input logic [29:0] b, input logic [29:0] c);
        drive(K_MEM, 1'b0, b, '0);
        drive(K_MEM | K_C2B, 1'b0, a, '0);
        drive(K_MEM | K_C2A, 1'b0, c, '0);
    endtask

    // Pop the oldest expectation and compare every register-derived output against it.
    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 31'd1, 31'd0);
            return;
        end
        e = sb.pop_front();
        check({e.name, ".A"}, {1'b0, reg_a}, {1'b0, e.a});
        check({e.name, ".B"}, reg_b, e.b);
        check({e.name, ".C"}, {1'b0, reg_c}, {1'b0, e.c});
        check({e.name, ".status"}, {28'd0, c1, c30, b0}, {28'd0, e.c[29], e.c[0], e.b[30]});
        check({e.name, ".mem_io"}, {1'b0, wdata}, {1'b0, e.c});
        check({e.name, ".io_bits"}, {27'd0, io_bits}, {27'd0, e.c[29:26]});
    endtask

    task automatic add_vec(input string n, input logic [29:0] a, input logic [29:0] b, input logic [29:0] c,
                           input cmd_t cmd, input logic sin, input logic [29:0] mem, input logic [29:0] pnl,
                           input logic [29:0] ea, input logic [30:0] eb, input logic [29:0] ec);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.c = c; v.cmd = cmd; v.sin = sin;
        v.mem = mem; v.pnl = pnl; v.ea = ea; v.eb = eb; v.ec = ec;
        vecs.push_back(v);
    endtask

    initial begin
        logic [30:0] wide_sum;
        exp_t        e;

        resetn = 1'b0;
        set_cmd('0, 1'b0, '0, '0);

        // Preload A, B, C; command; sin; mem; panel; expected A, B(31), C.
        add_vec("sum_ovf",      30'h20000000, 30'h20000000, 30'h00000011, K_SUM,           0, 0, 0, 30'h20000000, 31'h40000000, 30'h00000011);
        add_vec("sum_small",    30'h3,        30'h4,        30'h0,        K_SUM,           0, 0, 0, 30'h3,        31'h7,        30'h0);
        add_vec("not_ab",       30'h0000FFFF, 30'h15555555, 30'h0,        K_NOT_A|K_NOT_B, 0, 0, 0, 30'h3FFF0000, 31'h2AAAAAAA, 30'h0);
        add_vec("not_b",        30'h1,        30'h2,        30'h0,        K_NOT_B,         0, 0, 0, 30'h1,        31'h3FFFFFFD, 30'h0);
        add_vec("and",          30'h0FF00FF0, 30'h0,        30'h3C3C3C3C, K_AND,           0, 0, 0, 30'h0FF00FF0, 31'h0,        30'h0C300C30);
        add_vec("rsh",          30'h0,        30'h3,        30'h10,       K_RSH,           0, 0, 0, 30'h0,        31'h1,        30'h20000008);
        add_vec("lsb",          30'h0,        30'h20000001, 30'h20000000, K_LSB,           0, 0, 0, 30'h0,        31'h40000003, 30'h20000000);
        add_vec("lsc",          30'h0,        30'h0,        30'h20000001, K_LSC,           1, 0, 0, 30'h0,        31'h0,        30'h00000003);
        add_vec("lsc29",        30'h0,        30'h0,        30'h3FFFFFFF, K_LSC|K_LSC29,   0, 0, 0, 30'h0,        31'h0,        30'h3FFFFFFC);
        add_vec("lsc29_set",    30'h0,        30'h0,        30'h3FFFFFFF, K_LSC|K_LSC29|K_SET, 0, 0, 0, 30'h0,    31'h0,        30'h3FFFFFFD);
        add_vec("c29_alone",    30'h0,        30'h0,        30'h12345678, K_LSC29,         1, 0, 0, 30'h0,        31'h0,        30'h12345678);
        add_vec("swap_bc",      30'h0,        30'h7,        30'h9,        K_B2C|K_C2B,     0, 0, 0, 30'h0,        31'h9,        30'h7);
        add_vec("clr_a_pri",    30'h1234,     30'h0,        30'h15,       K_CLR_A|K_C2A,   0, 0, 0, 30'h0,        31'h0,        30'h15);
        add_vec("c2a_over_not", 30'h1234,     30'h0,        30'h15,       K_C2A|K_NOT_A,   0, 0, 0, 30'h15,       31'h0,        30'h15);
        add_vec("clr_b_pri",    30'h3,        30'h4,        30'h0,        K_CLR_B|K_SUM,   0, 0, 0, 30'h3,        31'h0,        30'h0);
        add_vec("c2b_over_sum", 30'h3,        30'h4,        30'h15,       K_C2B|K_SUM,     0, 0, 0, 30'h3,        31'h15,       30'h15);
        add_vec("mul_step",     30'h3,        30'h4,        30'h4,        K_SUM|K_RSH,     0, 0, 0, 30'h3,        31'h3,        30'h20000002);
        add_vec("mul_carry",    30'h3FFFFFFF, 30'h1,        30'h4,        K_SUM|K_RSH,     0, 0, 0, 30'h3FFFFFFF, 31'h20000000, 30'h2);
        add_vec("set_alone",    30'h0,        30'h0,        30'h8,        K_SET,           0, 0, 0, 30'h0,        31'h0,        30'h9);
        add_vec("clr_c_pri",    30'h0,        30'h0,        30'h5,        K_CLR_C|K_MEM,   0, 30'h77, 0, 30'h0,   31'h0,        30'h0);
        add_vec("b2c_over_mem", 30'h0,        30'h5,        30'h0,        K_B2C|K_MEM,     0, 30'h9, 0, 30'h0,    31'h5,        30'h5);
        add_vec("mem_over_arr", 30'h0,        30'h0,        30'h0,        K_MEM|K_ARR,     0, 30'h11, 30'h22, 30'h0, 31'h0,     30'h11);
        add_vec("arr",          30'h0,        30'h0,        30'h0,        K_ARR,           0, 0, 30'h2AAAAAAA, 30'h0, 31'h0,    30'h2AAAAAAA);
        add_vec("and_over_rsh", 30'h3F,       30'h2,        30'h0F,       K_AND|K_RSH,     0, 0, 0, 30'h3F,       31'h1,        30'h0F);
        add_vec("lsb_over_rsh", 30'h0,        30'h1,        30'h0,        K_LSB|K_RSH,     0, 0, 0, 30'h0,        31'h2,        30'h20000000);
        add_vec("sum_over_lsb", 30'h1,        30'h1,        30'h0,        K_SUM|K_LSB,     0, 0, 0, 30'h1,        31'h2,        30'h0);
        add_vec("idle_hold",    30'h0ABCDEF0, 30'h15,       30'h2,        '0,              1, 30'h5, 30'h6, 30'h0ABCDEF0, 31'h15, 30'h2);
        add_vec("clr_all",      30'h1,        30'h2,        30'h3,        K_CLR_A|K_CLR_B|K_CLR_C, 0, 0, 0, 30'h0, 31'h0,      30'h0);

        // Held in reset: everything reads zero.
        repeat (2) @(negedge clk);
        check("reset.A", {1'b0, reg_a}, 31'd0);
        check("reset.B", reg_b, 31'd0);
        check("reset.C", {1'b0, reg_c}, 31'd0);
        check("reset.carry", {30'd0, carry_out}, 31'd0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            preload(vecs[i].a, vecs[i].b, vecs[i].c);
            // Carry is combinational on the preloaded A and B, before any command edge.
            wide_sum = {1'b0, vecs[i].a} + {1'b0, vecs[i].b};
            check({vecs[i].name, ".carry"}, {30'd0, carry_out}, {30'd0, wide_sum[30]});
            e.name = vecs[i].name; e.a = vecs[i].ea; e.b = vecs[i].eb; e.c = vecs[i].ec;
            sb.push_back(e);
            drive(vecs[i].cmd, vecs[i].sin, vecs[i].mem, vecs[i].pnl);
            compare_pop();
        end

        // Shift-and-add multiply 5 x 3: multiplier bits 0 and 1 are set, so only the first two steps add.
        preload(30'd5, 30'd0, 30'd3);
        for (int i = 0; i < 30; i++) begin
            if (i == 29) begin
                e.name = "mul_5x3"; e.a = 30'd5; e.b = 31'd0; e.c = 30'd15;
                sb.push_back(e);
            end
            drive((i < 2) ? (K_SUM | K_RSH) : K_RSH, 1'b0, '0, '0);
        end
        compare_pop();

        // Reset asserted between edges clears immediately, even with a command pending.
        preload(30'h1, 30'h2, 30'h3);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst.A", {1'b0, reg_a}, 31'd0);
        check("async_rst.B", reg_b, 31'd0);
        check("async_rst.C", {1'b0, reg_c}, 31'd0);
        check("async_rst.carry", {30'd0, carry_out}, 31'd0);
        drive(K_SUM | K_MEM, 1'b0, 30'h3FF, '0);
        check("rst_held.C", {1'b0, reg_c}, 31'd0);
        check("rst_held.status", {28'd0, c1, c30, b0}, 31'd0);
        @(negedge clk);
        resetn = 1'b1;
        e.name = "post_rst"; e.a = 30'd0; e.b = 31'd0; e.c = 30'h15;
        sb.push_back(e);
        drive(K_MEM, 1'b0, 30'h15, '0);
        compare_pop();

        check("scoreboard_drained", sb.size(), 31'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
